hilo_unit: RTL

//  Downstream consumer of the 64-bit divider (and multiplier) result. Tracks the multi-cycle

---
 rtl/hilo_unit_if.sv | 34 +++
 rtl/hilo_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hilo_unit_if.sv
// ---------------------------------------------------------------------------
// hilo_unit_if
//   Bundles the function-code / result bus between the issuing pipeline stage
//   (master) and the HI/LO unit (slave).
//   Signals:
//     Signal   [5:0]   function code from the issuer, held for the operation
//     divOut   [63:0]  registered divider result {remainder, quotient}
//     mulOut   [63:0]  registered multiplier result {product hi, product lo}
//     dataA    [31:0]  operand for MTHI/MTLO (used only with HILO_MTX_EN)
//     dataOut  [31:0]  registered read data towards the ALU output mux
//     outValid         one-cycle pulse when dataOut was updated by a read
//     busy             high while a DIVU/MULTU is in flight
//     done             one-cycle pulse on the cycle after HI/LO capture
// ---------------------------------------------------------------------------
interface hilo_unit_if;
    logic [5:0]  Signal;
    logic [63:0] divOut;
    logic [63:0] mulOut;
    logic [31:0] dataA;
    logic [31:0] dataOut;
    logic        outValid;
    logic        busy;
    logic        done;

    modport master (
        output Signal, divOut, mulOut, dataA,
        input  dataOut, outValid, busy, done
    );

    modport slave (
        input  Signal, divOut, mulOut, dataA,
        output dataOut, outValid, busy, done
    );
endinterface

// File: rtl/hilo_unit.sv
// ---------------------------------------------------------------------------
// hilo_unit
//   Tracks a multi-cycle DIVU/MULTU by function code, captures the 64-bit
//   result into HI/LO when the operation completes and serves MFHI/MFLO reads.
//   Reads issued while an operation is in flight are held as a single pending
//   request and delivered on the first idle edge after capture.
//   Optional feature macro: HILO_MTX_EN enables MTHI/MTLO writes from dataA.
//   Ports:
//     clk    clock, all state changes on the rising edge
//     reset  synchronous reset, active low
//     bus    hilo_unit_if.slave (Signal, divOut, mulOut, dataA in;
//            dataOut, outValid, busy, done out, all outputs registered)
//   Parameter:
//     LATENCY  edges from the issue edge to the capture edge (1..63)
// ---------------------------------------------------------------------------
module hilo_unit #(
    parameter int LATENCY = 32
) (
    input  logic       clk,
    input  logic       reset,
    hilo_unit_if.slave bus
);

    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
`ifdef HILO_MTX_EN
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MTLO  = 6'b010011;
`endif
    localparam logic [5:0] LAT_C = 6'(LATENCY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_DIV = 2'd1,
        RUN_MUL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_HI   = 2'd1,
        PEND_LO   = 2'd2
    } pend_t;

    state_t      state_q,     state_d;
    pend_t       pend_q,      pend_d;
    logic [5:0]  cnt_q,       cnt_d;
    logic [31:0] hi_q,        hi_d;
    logic [31:0] lo_q,        lo_d;
    logic [31:0] data_out_q,  data_out_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic [63:0] src_s;
    logic        unused_data_a_s;

    // dataA only feeds HI/LO when the move-to feature is built in
    assign unused_data_a_s = ^bus.dataA;

    // Next-state and next-output logic for the operation tracker and read port
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        src_s       = bus.divOut;

        case (state_q)
            IDLE: begin
                // A read left over from the operation wins over a fresh read
                if (pend_q != PEND_NONE) begin
                    data_out_d  = (pend_q == PEND_HI) ? hi_q : lo_q;
                    out_valid_d = 1'b1;
                    pend_d      = PEND_NONE;
                end else if (bus.Signal == MFHI) begin
                    data_out_d  = hi_q;
                    out_valid_d = 1'b1;
                end else if (bus.Signal == MFLO) begin
                    data_out_d  = lo_q;
                    out_valid_d = 1'b1;
                end else begin
                    data_out_d  = data_out_q;
                end

                if (bus.Signal == DIVU) begin
                    state_d = RUN_DIV;
                    cnt_d   = 6'd1;
                end else if (bus.Signal == MULTU) begin
                    state_d = RUN_MUL;
                    cnt_d   = 6'd1;
                end else begin
                    cnt_d   = 6'd0;
                end
`ifdef HILO_MTX_EN
                if (bus.Signal == MTHI) begin
                    hi_d = bus.dataA;
                end else if (bus.Signal == MTLO) begin
                    lo_d = bus.dataA;
                end else begin
                    hi_d = hi_q;
                end
`endif
            end

            RUN_DIV, RUN_MUL: begin
                // Later read request replaces an earlier one
                if (bus.Signal == MFHI) begin
                    pend_d = PEND_HI;
                end else if (bus.Signal == MFLO) begin
                    pend_d = PEND_LO;
                end else begin
                    pend_d = pend_q;
                end

                if (cnt_q == LAT_C) begin
                    src_s   = (state_q == RUN_DIV) ? bus.divOut : bus.mulOut;
                    hi_d    = src_s[63:32];
                    lo_d    = src_s[31:0];
                    cnt_d   = 6'd0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                end
            end

            default: begin
                state_d = IDLE;
                pend_d  = PEND_NONE;
                cnt_d   = 6'd0;
            end
        endcase

        // Registered busy mirrors whether the next state is an active run
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pend_q      <= PEND_NONE;
            cnt_q       <= 6'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            data_out_q  <= 32'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.dataOut  = data_out_q;
    assign bus.outValid = out_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
